// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared states, direction codes and neighbour helper for the maze DFS engine
package maze_pkg;

  typedef enum logic [2:0] {IDLE, MARK, CHECK, NEXT, EVAL, BACK, REPLAY} state_t;

  localparam logic [1:0] DIR_E = 2'd0;
  localparam logic [1:0] DIR_N = 2'd1;
  localparam logic [1:0] DIR_W = 2'd2;
  localparam logic [1:0] DIR_S = 2'd3;
  localparam logic [2:0] DIR_END = 3'd4;

  localparam int NB_W = 32;

  // Returns {in_bounds, loc}; loc = {row, col} packed with col in the low col_w bits.
  function automatic logic [NB_W:0] neighbour(input logic [NB_W-1:0] loc, input logic [1:0] dir,
                                              input int row_w, input int col_w);
    int unsigned rows, cols, row, col;
    logic ok;
    rows = 32'd1 << row_w;
    cols = 32'd1 << col_w;
    row  = loc >> col_w;
    col  = loc & (cols - 1);
    ok   = 1'b0;
    case (dir)
      DIR_E: begin ok = (col + 1 < cols); col = col + 1; end
      DIR_N: begin ok = (row != 0);       row = row - 1; end
      DIR_W: begin ok = (col != 0);       col = col - 1; end
      default: begin ok = (row + 1 < rows); row = row + 1; end
    endcase
    return {ok, (row << col_w) | (col & (cols - 1))};
  endfunction

endpackage

// File: rtl/maze_dfs_engine_loc_stack.sv
// rtl/maze_dfs_engine_loc_stack.sv - LIFO of path locations with a random-access replay port
module loc_stack #(
  parameter int LOC_W = 8,
  parameter int DEPTH = 256,
  parameter int SP_W  = $clog2(DEPTH + 1),
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] push_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [LOC_W-1:0] rd_data,
  output logic [LOC_W-1:0] top_data,
  output logic [SP_W-1:0]  sp,
  output logic             full,
  output logic             empty
);

  logic [LOC_W-1:0] mem [1 << IDX_W];
  logic [IDX_W-1:0] top_idx;

  assign full     = (sp == SP_W'(DEPTH));
  assign empty    = (sp == '0);
  // sp == DEPTH may truncate to 0 when DEPTH is a power of two; the wrap still lands on DEPTH-1.
  assign top_idx  = sp[IDX_W-1:0] - IDX_W'(1);
  assign top_data = mem[top_idx];
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sp <= '0;
    else if (clear)          sp <= '0;
    else if (push && !full)  sp <= sp + SP_W'(1);
    else if (pop && !empty)  sp <= sp - SP_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[sp[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/maze_dfs_engine.sv
// rtl/maze_dfs_engine.sv - depth-first maze solver over a 1-bit-per-cell map RAM with path replay
module maze_dfs_engine
  import maze_pkg::*;
#(
  parameter int ROW_W       = 4,
  parameter int COL_W       = 4,
  parameter int STACK_DEPTH = 256,
  parameter int LOC_W       = ROW_W + COL_W,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LOC_W-1:0] src_loc,
  input  logic [LOC_W-1:0] dst_loc,
  output logic             map_rd_en,
  output logic             map_wr_en,
  output logic [LOC_W-1:0] map_addr,
  output logic             map_wr_data,
  input  logic             map_rd_data,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             overflow,
  output logic [SP_W:0]    path_len,
  output logic             path_valid,
  output logic [LOC_W-1:0] path_loc,
  input  logic             path_ready
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_t           state, state_next;
  logic [LOC_W-1:0] curr, dst_r, nb_loc, stack_top, stack_rd;
  logic [2:0]       dir;
  logic [SP_W-1:0]  sp, rep_idx;
  logic [NB_W:0]    nb;
  logic             nb_ok, full, empty, push, pop, clear, hs, last_beat;

  assign nb     = neighbour(NB_W'(curr), dir[1:0], ROW_W, COL_W);
  assign nb_ok  = nb[NB_W] && (nb[NB_W-1:LOC_W] == '0);
  assign nb_loc = nb[LOC_W-1:0];

  assign map_wr_data = 1'b1;
  assign busy        = (state != IDLE);
  assign path_valid  = (state == REPLAY);
  assign hs          = path_valid && path_ready;
  // Stack entries replay first; the destination is never pushed, so it comes from curr.
  assign last_beat   = (rep_idx == sp);
  assign path_loc    = !path_valid ? '0 : (last_beat ? curr : stack_rd);

  loc_stack #(.LOC_W(LOC_W), .DEPTH(STACK_DEPTH), .SP_W(SP_W), .IDX_W(IDX_W)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (push),
    .pop      (pop),
    .push_data(curr),
    .rd_addr  (rep_idx[IDX_W-1:0]),
    .rd_data  (stack_rd),
    .top_data (stack_top),
    .sp       (sp),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    map_rd_en  = 1'b0;
    map_wr_en  = 1'b0;
    map_addr   = '0;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    case (state)
      IDLE:   if (start) begin clear = 1'b1; state_next = MARK; end
      MARK:   begin map_wr_en = 1'b1; map_addr = curr; state_next = CHECK; end
      CHECK:  state_next = (curr == dst_r) ? REPLAY : NEXT;
      NEXT: begin
        if (dir == DIR_END) state_next = BACK;
        else if (nb_ok) begin map_rd_en = 1'b1; map_addr = nb_loc; state_next = EVAL; end
      end
      EVAL: begin
        if (map_rd_data) state_next = NEXT;
        else if (full)   state_next = IDLE;
        else begin push = 1'b1; state_next = MARK; end
      end
      BACK: begin
        if (empty) state_next = IDLE;
        else begin pop = 1'b1; state_next = NEXT; end
      end
      REPLAY: if (hs && last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curr     <= '0;
      dst_r    <= '0;
      dir      <= '0;
      rep_idx  <= '0;
      done     <= 1'b0;
      fail     <= 1'b0;
      overflow <= 1'b0;
      path_len <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          curr     <= src_loc;
          dst_r    <= dst_loc;
          dir      <= '0;
          rep_idx  <= '0;
          done     <= 1'b0;
          fail     <= 1'b0;
          overflow <= 1'b0;
          path_len <= '0;
        end
        CHECK: if (curr == dst_r) begin
          path_len <= {1'b0, sp} + (SP_W + 1)'(1);
          done     <= 1'b1;
        end
        NEXT: if (dir != DIR_END && !nb_ok) dir <= dir + 3'd1;
        EVAL: begin
          if (map_rd_data) dir <= dir + 3'd1;
          else if (full) begin fail <= 1'b1; overflow <= 1'b1; end
          else begin curr <= nb_loc; dir <= '0; end
        end
        BACK: begin
          if (empty) fail <= 1'b1;
          else begin curr <= stack_top; dir <= '0; end
        end
        REPLAY: if (hs && !last_beat) rep_idx <= rep_idx + SP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_dfs_engine.sv
// tb/tb_maze_dfs_engine.sv - randomized and directed bench for maze_dfs_engine on a 4x4 grid
module tb_maze_dfs_engine;

  logic clk = 1'b0;
  logic rst, start, path_ready;
  logic [3:0] src, dst;
  logic [1:0] rd_data;
  logic [1:0][15:0] mem;
  wire  [1:0] rd_en, wr_en, wr_data, busy, done, fail, ovf, pvalid;
  wire  [1:0][3:0] addr, ploc;
  wire  [5:0] plen0;
  wire  [3:0] plen1;

  int passes = 0, checks = 0, fails = 0;
  int nrd[2], nwr[2], nbad[2], done_cyc[2];
  int bq0[$], bq1[$];

  always #5 clk = ~clk;

  maze_dfs_engine #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(16)) dut0 (
    .clk(clk), .rst(rst), .start(start), .src_loc(src), .dst_loc(dst),
    .map_rd_en(rd_en[0]), .map_wr_en(wr_en[0]), .map_addr(addr[0]), .map_wr_data(wr_data[0]),
    .map_rd_data(rd_data[0]), .busy(busy[0]), .done(done[0]), .fail(fail[0]), .overflow(ovf[0]),
    .path_len(plen0), .path_valid(pvalid[0]), .path_loc(ploc[0]), .path_ready(path_ready));

  maze_dfs_engine #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .src_loc(src), .dst_loc(dst),
    .map_rd_en(rd_en[1]), .map_wr_en(wr_en[1]), .map_addr(addr[1]), .map_wr_data(wr_data[1]),
    .map_rd_data(rd_data[1]), .busy(busy[1]), .done(done[1]), .fail(fail[1]), .overflow(ovf[1]),
    .path_len(plen1), .path_valid(pvalid[1]), .path_loc(ploc[1]), .path_ready(path_ready));

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rd_data[i] <= rd_en[i] ? mem[i][addr[i]] : 1'b0;
      if (wr_en[i]) mem[i][addr[i]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain DFS: take the first unvisited in-bounds neighbour in E,N,W,S order, else backtrack.
  task automatic model(input logic [15:0] walls, input int s, input int d, input int depth,
                       output int m_done, output int m_ovf, output int m_marks,
                       output int m_reads, output int m_path[$]);
    bit vis[16];
    int stk[$];
    int cur, nxt, r, c, nr, nc;
    for (int k = 0; k < 16; k++) vis[k] = walls[k];
    m_done = 0; m_ovf = 0; m_reads = 0; m_path = {};
    cur = s; vis[cur] = 1; m_marks = 1;
    for (int step = 0; step < 1000; step++) begin
      if (cur == d) begin m_done = 1; m_path = stk; m_path.push_back(cur); return; end
      nxt = -1; r = cur / 4; c = cur % 4;
      for (int k = 0; k < 4 && nxt < 0; k++) begin
        nr = r + ((k == 3) ? 1 : 0) - ((k == 1) ? 1 : 0);
        nc = c + ((k == 0) ? 1 : 0) - ((k == 2) ? 1 : 0);
        if (nr >= 0 && nr < 4 && nc >= 0 && nc < 4) begin
          m_reads++;
          if (!vis[nr * 4 + nc]) nxt = nr * 4 + nc;
        end
      end
      if (nxt >= 0) begin
        if (stk.size() == depth) begin m_ovf = 1; return; end
        stk.push_back(cur); cur = nxt; vis[cur] = 1; m_marks++;
      end else if (stk.size() == 0) return;
      else cur = stk.pop_back();
    end
  endtask

  task automatic run(input logic [15:0] walls, input int s, input int d, input bit toggle,
                     input string tag);
    bit fin;
    logic [1:0] stall;
    logic [1:0][3:0] prev;
    mem = {walls, walls}; src = 4'(s); dst = 4'(d); path_ready = 1'b1;
    stall = '0; prev = '0; bq0 = {}; bq1 = {};
    for (int i = 0; i < 2; i++) begin nrd[i] = 0; nwr[i] = 0; nbad[i] = 0; done_cyc[i] = 0; end
    @(negedge clk); start = 1'b1;
    fin = 0;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(negedge clk); start = 1'b0;
      path_ready = toggle ? (cyc % 4 == 0 || cyc % 4 == 1) : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (rd_en[i]) nrd[i]++;
        if (wr_en[i]) nwr[i]++;
        if (rd_en[i] && wr_en[i]) nbad[i]++;
        if (wr_en[i] && !wr_data[i]) nbad[i]++;
        if (stall[i] && (!pvalid[i] || ploc[i] != prev[i])) nbad[i]++;
        if (done[i] && done_cyc[i] == 0) done_cyc[i] = cyc;
        if (pvalid[i] && path_ready) begin
          if (i == 0) bq0.push_back(int'(ploc[i])); else bq1.push_back(int'(ploc[i]));
        end
        stall[i] = pvalid[i] && !path_ready;
        prev[i] = ploc[i];
      end
      if (busy == 2'b00) fin = 1;
    end
    check({tag, ".finished"}, 32'(fin), 1);
  endtask

  task automatic verify(input int i, input logic [15:0] walls, input int s, input int d,
                        input string tag);
    int md, mo, mm, mr;
    int mp[$];
    int q[$];
    int len;
    model(walls, s, d, (i == 0) ? 16 : 4, md, mo, mm, mr, mp);
    if (i == 0) begin q = bq0; len = int'(plen0); end
    else begin q = bq1; len = int'(plen1); end
    check($sformatf("%s.%0d.done", tag, i), 32'(done[i]), 32'(md));
    check($sformatf("%s.%0d.fail", tag, i), 32'(fail[i]), 32'(md == 0));
    check($sformatf("%s.%0d.overflow", tag, i), 32'(ovf[i]), 32'(mo));
    check($sformatf("%s.%0d.busy", tag, i), 32'(busy[i]), 0);
    check($sformatf("%s.%0d.path_len", tag, i), 32'(len), 32'(md ? mp.size() : 0));
    check($sformatf("%s.%0d.writes", tag, i), 32'(nwr[i]), 32'(mm));
    check($sformatf("%s.%0d.reads", tag, i), 32'(nrd[i]), 32'(mr));
    check($sformatf("%s.%0d.protocol", tag, i), 32'(nbad[i]), 0);
    check($sformatf("%s.%0d.beats", tag, i), 32'(q.size()), 32'(md ? mp.size() : 0));
    if (md) for (int k = 0; k < mp.size() && k < q.size(); k++)
      check($sformatf("%s.%0d.beat%0d", tag, i, k), 32'(q[k]), 32'(mp[k]));
  endtask

  initial begin
    int exp_path[13];
    logic [15:0] w;
    int s, d, n;
    exp_path = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11, 15};
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; path_ready = 1'b0; mem = '0;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 0);
    check("reset.flags", 32'({done, fail, ovf, pvalid}), 0);
    check("reset.strobes", 32'({rd_en, wr_en}), 0);
    check("reset.path", 32'({plen0, plen1, ploc, addr}), 0);
    rst = 1'b0;

    run(16'h0000, 0, 15, 1'b0, "free");
    verify(0, 16'h0000, 0, 15, "free");
    verify(1, 16'h0000, 0, 15, "free");
    check("free.len13", 32'(plen0), 13);
    for (int k = 0; k < 13; k++) check($sformatf("free.const%0d", k), 32'(bq0[k]), 32'(exp_path[k]));
    check("ovf.flag", 32'({fail[1], ovf[1], done[1]}), 32'b110);
    check("ovf.writes", 32'(nwr[1]), 5);

    run(16'h0000, 5, 5, 1'b0, "same");
    verify(0, 16'h0000, 5, 5, "same");
    check("same.latency", 32'(done_cyc[0] > 0 && done_cyc[0] <= 3), 1);
    check("same.noread", 32'(nrd[0] + nrd[1]), 0);
    check("same.beat", 32'(bq0.size() == 1 ? bq0[0] : -1), 5);

    run(16'h0012, 0, 15, 1'b0, "walled");
    verify(0, 16'h0012, 0, 15, "walled");
    check("walled.flags", 32'({done[0], fail[0], ovf[0]}), 32'b010);

    run(16'h0000, 0, 15, 1'b1, "toggle");
    verify(0, 16'h0000, 0, 15, "toggle");
    check("toggle.handshakes", 32'(bq0.size()), 13);

    mem = '0; src = 4'd0; dst = 4'd15;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (n < 100 && !rd_en[0]) begin @(negedge clk); n++; end
    check("rst.reach_eval", 32'(rd_en[0]), 1);
    @(posedge clk); #1 rst = 1'b1; #1;
    check("rst.outputs", 32'({busy, done, fail, ovf, pvalid, rd_en, wr_en}), 0);
    check("rst.buses", 32'({plen0, plen1, ploc, addr}), 0);
    @(negedge clk); rst = 1'b0;
    run(16'h0000, 15, 0, 1'b0, "after_rst");
    verify(0, 16'h0000, 15, 0, "after_rst");

    for (int t = 0; t < 10; t++) begin
      w = 16'($urandom) & 16'($urandom);
      s = int'($urandom_range(15)); d = int'($urandom_range(15));
      run(w, s, d, 1'($urandom_range(1)), $sformatf("rand%0d", t));
      verify(0, w, s, d, $sformatf("rand%0d", t));
      verify(1, w, s, d, $sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
